// File: rtl/formatter_pkg.sv
// Shared types and constants for the downlink packet formatter.
// Holds channel codes, the FSM state type and the payload-length decode.
package formatter_pkg;

  localparam int FIFO_WIDE = 32;

  localparam logic [1:0] CH0     = 2'b00;
  localparam logic [1:0] CH1     = 2'b01;
  localparam logic [1:0] CH2     = 2'b10;
  localparam logic [1:0] CH_NONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SEND  = 3'd2,
    ST_PAR   = 3'd3,
    ST_DRAIN = 3'd4
  } fmt_state_e;

  // Payload length code 0..3 maps to 4, 8, 16, 32 words.
  function automatic logic [5:0] len_decode(input logic [1:0] code);
    return 6'd4 << code;
  endfunction

endpackage

// File: rtl/fmt_out_reg.sv
// Output holding register for the formatter's valid/ready output port.
// A load always wins; otherwise an accepted beat empties the register.
module fmt_out_reg
  import formatter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [FIFO_WIDE-1:0] i_data,
  input  logic [1:0]           i_chid,
  input  logic                 i_start,
  input  logic                 i_end,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [FIFO_WIDE-1:0] o_data,
  output logic [1:0]           o_chid,
  output logic                 o_start,
  output logic                 o_end
);

  logic                 r_valid;
  logic [FIFO_WIDE-1:0] r_data;
  logic [1:0]           r_chid;
  logic                 r_start;
  logic                 r_end;

  // The caller only asserts i_load when the register is empty or being
  // accepted, so a stalled beat (valid && !ready) is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chid  <= CH_NONE;
      r_start <= 1'b0;
      r_end   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_chid  <= i_chid;
      r_start <= i_start;
      r_end   <= i_end;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
      r_end   <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_chid  = r_chid;
  assign o_start = r_start;
  assign o_end   = r_end;

endmodule

// File: rtl/formatter.sv
// Packs arbiter words into fixed-length single-channel packets with a
// trailing XOR parity word, requesting the downstream bus before each one.
module formatter
  import formatter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fmt_arb_ready,
  input  logic [1:0]           fmt_ch_id,
  input  logic [FIFO_WIDE-1:0] fmt_data_in,
  output logic                 fmt_arb_valid,
  input  logic [1:0]           fmt_pkt_len,
  output logic                 fmt_req,
  input  logic                 fmt_grant,
  output logic                 fmt_out_valid,
  input  logic                 fmt_out_ready,
  output logic [FIFO_WIDE-1:0] fmt_data,
  output logic [1:0]           fmt_chid,
  output logic                 fmt_start,
  output logic                 fmt_end,
  output fmt_state_e           o_dbg_state
);

  // Handshakes: a word moves on the arbiter side at a clock edge where
  // fmt_arb_ready && fmt_arb_valid, and on the output side where
  // fmt_out_valid && fmt_out_ready; an unaccepted output beat holds steady.

  fmt_state_e           r_state;
  fmt_state_e           w_next;
  logic [1:0]           r_lock_ch;
  logic [1:0]           r_len;
  logic [5:0]           r_cnt;
  logic [FIFO_WIDE-1:0] r_parity;

  logic                 w_out_free;
  logic                 w_pull;
  logic                 w_last;
  logic                 w_load;
  logic [FIFO_WIDE-1:0] w_ld_data;
  logic                 w_ld_start;
  logic                 w_ld_end;

  assign w_out_free = !fmt_out_valid || fmt_out_ready;
  assign w_pull     = (r_state == ST_SEND) && fmt_arb_ready &&
                      (fmt_ch_id == r_lock_ch) && w_out_free;
  assign w_last     = (r_cnt == (len_decode(r_len) - 6'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= CH_NONE;
      r_len     <= 2'd0;
      r_cnt     <= '0;
      r_parity  <= '0;
    end else begin
      r_state <= w_next;
      // Channel and length are frozen for the whole packet at lock time.
      if (r_state == ST_IDLE && w_next == ST_REQ) begin
        r_lock_ch <= fmt_ch_id;
        r_len     <= fmt_pkt_len;
      end
      if (r_state == ST_REQ && fmt_grant) begin
        r_cnt    <= '0;
        r_parity <= '0;
      end else if (w_pull) begin
        r_cnt    <= r_cnt + 6'd1;
        r_parity <= r_parity ^ fmt_data_in;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    fmt_req       = 1'b0;
    fmt_arb_valid = 1'b0;
    w_load        = 1'b0;
    w_ld_data     = fmt_data_in;
    w_ld_start    = 1'b0;
    w_ld_end      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fmt_arb_ready && fmt_ch_id != CH_NONE) w_next = ST_REQ;
      end
      ST_REQ: begin
        fmt_req = 1'b1;
        if (fmt_grant) w_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_pull) begin
          fmt_arb_valid = 1'b1;
          w_load        = 1'b1;
          w_ld_start    = (r_cnt == '0);
          if (w_last) w_next = ST_PAR;
        end
      end
      ST_PAR: begin
        if (w_out_free) begin
          w_load    = 1'b1;
          w_ld_data = r_parity;
          w_ld_end  = 1'b1;
          w_next    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fmt_out_valid && fmt_end && fmt_out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  fmt_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_ld_data),
    .i_chid  (r_lock_ch),
    .i_start (w_ld_start),
    .i_end   (w_ld_end),
    .i_ready (fmt_out_ready),
    .o_valid (fmt_out_valid),
    .o_data  (fmt_data),
    .o_chid  (fmt_chid),
    .o_start (fmt_start),
    .o_end   (fmt_end)
  );

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_formatter.sv
// Self-checking bench for the formatter: directed packet table, hand-built
// corner sequences and random packets, all scored against an expected beat queue.
module tb_formatter;
  import formatter_pkg::*;

  localparam int W  = FIFO_WIDE;
  localparam int BW = W + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         fmt_arb_ready;
  logic [1:0]   fmt_ch_id;
  logic [W-1:0] fmt_data_in;
  logic         fmt_arb_valid;
  logic [1:0]   fmt_pkt_len;
  logic         fmt_req;
  logic         fmt_grant;
  logic         fmt_out_valid;
  logic         fmt_out_ready;
  logic [W-1:0] fmt_data;
  logic [1:0]   fmt_chid;
  logic         fmt_start;
  logic         fmt_end;
  fmt_state_e   dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expected output beats: {data, chid, start, end}
  logic [BW-1:0] exp_q[$];
  int beats_pkt = 0;
  int start_cyc = 0;
  int end_cyc   = 0;

  typedef struct {
    logic [1:0]   ch;
    logic [1:0]   code;
    logic [W-1:0] base;
    int           mode;
    int           sw;
    int           gdly;
    logic [W-1:0] exp_par;
    int           exp_beats;
    logic         chk_timing;
  } vec_t;

  vec_t tbl[4];

  formatter dut (
    .clk           (clk),
    .rst           (rst),
    .fmt_arb_ready (fmt_arb_ready),
    .fmt_ch_id     (fmt_ch_id),
    .fmt_data_in   (fmt_data_in),
    .fmt_arb_valid (fmt_arb_valid),
    .fmt_pkt_len   (fmt_pkt_len),
    .fmt_req       (fmt_req),
    .fmt_grant     (fmt_grant),
    .fmt_out_valid (fmt_out_valid),
    .fmt_out_ready (fmt_out_ready),
    .fmt_data      (fmt_data),
    .fmt_chid      (fmt_chid),
    .fmt_start     (fmt_start),
    .fmt_end       (fmt_end),
    .o_dbg_state   (dbg_state)
  );

  // Clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: output beats and hold stability
  logic [W-1:0] p_data;
  logic [1:0]   p_chid;
  logic         p_start;
  logic         p_end;
  logic         p_hold = 1'b0;

  always @(negedge clk) begin
    logic [BW-1:0] e;
    if (rst) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        check("hold_valid", fmt_out_valid, 1);
        check("hold_beat", {fmt_data, fmt_chid, fmt_start, fmt_end},
              {p_data, p_chid, p_start, p_end});
      end
      if (fmt_out_valid && fmt_out_ready) begin
        beats_pkt++;
        check("beat_queued", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", {fmt_data, fmt_chid, fmt_start, fmt_end}, e);
        end
        if (fmt_start) start_cyc = cyc;
        if (fmt_end)   end_cyc   = cyc;
      end
      p_hold  = fmt_out_valid && !fmt_out_ready;
      p_data  = fmt_data;
      p_chid  = fmt_chid;
      p_start = fmt_start;
      p_end   = fmt_end;
    end
  end

  // Drives one packet's worth of arbiter words, grant and output ready.
  // mode: 0 ready always, 1 ready toggles, 2 random gaps/switches/ready.
  // rst_at >= 0 pulses reset once that many payload words have been pulled.
  task automatic run_packet(input logic [1:0] ch, input logic [1:0] code,
                            input logic [1:0] code_after, input int mode,
                            input int gdly, input int sw, input int rst_at,
                            input logic rnd, input logic [W-1:0] base,
                            input logic use_par, input logic [W-1:0] par_val,
                            input logic chk_timing);
    int           n;
    logic [W-1:0] words[$];
    logic [W-1:0] par;
    logic [1:0]   other;
    int           pulled, gwait, sw_left, guard, g_cyc;
    logic         took, req_seen, granted, gnt_on, in_sw;
    n   = 4 << code;
    par = '0;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] w;
      w = rnd ? W'($urandom) : base + W'(i);
      words.push_back(w);
      par ^= w;
      exp_q.push_back({w, ch, (i == 0), 1'b0});
    end
    exp_q.push_back({(use_par ? par_val : par), ch, 1'b0, 1'b1});
    other    = (ch == CH2) ? CH0 : CH2;
    pulled   = 0;
    gwait    = 0;
    sw_left  = sw;
    guard    = 0;
    g_cyc    = 0;
    took     = 1'b0;
    req_seen = 1'b0;
    granted  = 1'b0;
    gnt_on   = 1'b0;
    beats_pkt = 0;
    fmt_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (took && words.size() != 0) begin
        void'(words.pop_front());
        pulled++;
      end
      if (pulled == n && exp_q.size() == 0) begin
        check("beat_count", beats_pkt, n + 1);
        if (chk_timing) begin
          check("first_beat_latency", start_cyc - g_cyc, 1);
          check("burst_span", end_cyc - start_cyc, n);
        end
        fmt_arb_ready = 1'b0;
        fmt_ch_id     = CH_NONE;
        fmt_grant     = 1'b0;
        return;
      end
      if (rst_at >= 0 && pulled == rst_at) begin
        rst = 1'b1;
        fmt_arb_ready = 1'b0;
        fmt_ch_id     = CH_NONE;
        fmt_grant     = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", fmt_out_valid, 0);
        check("rst_req", fmt_req, 0);
        check("rst_chid", fmt_chid, CH_NONE);
        check("rst_start_end", {fmt_start, fmt_end}, 0);
        check("rst_data", fmt_data, 0);
        check("rst_arb_valid", fmt_arb_valid, 0);
        exp_q.delete();
        return;
      end
      guard++;
      if (guard > 600) begin
        check("packet_timeout_pending", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b1;
        fmt_arb_ready = 1'b0;
        fmt_ch_id     = CH_NONE;
        fmt_grant     = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      // Arbiter side
      in_sw = 1'b0;
      if (!req_seen) begin
        fmt_arb_ready = 1'b1;
        fmt_ch_id     = ch;
        fmt_pkt_len   = code;
        fmt_data_in   = words[0];
      end else begin
        fmt_pkt_len = code_after;
        if (words.size() == 0) begin
          fmt_arb_ready = 1'($urandom_range(0, 1));
          fmt_ch_id     = CH_NONE;
          fmt_data_in   = $urandom;
        end else if (pulled >= 2 && sw_left > 0) begin
          fmt_arb_ready = 1'b1;
          fmt_ch_id     = other;
          fmt_data_in   = $urandom;
          sw_left--;
          in_sw = 1'b1;
        end else if (mode == 2 && $urandom_range(0, 5) == 0) begin
          fmt_arb_ready = 1'b1;
          fmt_ch_id     = other;
          fmt_data_in   = $urandom;
          in_sw = 1'b1;
        end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
          fmt_arb_ready = 1'b0;
          fmt_ch_id     = ch;
          fmt_data_in   = $urandom;
        end else begin
          fmt_arb_ready = 1'b1;
          fmt_ch_id     = ch;
          fmt_data_in   = words[0];
        end
      end
      // Receiver side
      case (mode)
        0:       fmt_out_ready = 1'b1;
        1:       fmt_out_ready = ~fmt_out_ready;
        default: fmt_out_ready = 1'($urandom_range(0, 1));
      endcase
      // Downstream grant
      if (req_seen && !granted) begin
        if (gwait >= gdly) gnt_on = 1'b1;
        else gwait++;
      end
      fmt_grant = gnt_on && !granted;

      @(negedge clk);
      took = fmt_arb_valid;
      if (req_seen && !granted && !gnt_on) begin
        check("req_held_until_grant", fmt_req, 1);
        check("no_pull_before_grant", fmt_arb_valid, 0);
        check("no_beat_before_grant", fmt_out_valid, 0);
      end
      if (!req_seen) begin
        if (fmt_req) req_seen = 1'b1;
      end else if (!granted && !fmt_req) begin
        granted = 1'b1;
        g_cyc   = cyc;
        check("req_drop_after_grant", gnt_on, 1);
      end
      if (took) begin
        check("pull_channel", {fmt_arb_ready, fmt_ch_id}, {1'b1, ch});
        check("pull_has_word", words.size() != 0, 1);
        check("pull_after_grant", granted, 1);
      end
      if (in_sw) check("switch_stall", fmt_arb_valid, 0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    fmt_arb_ready = 1'b0;
    fmt_ch_id     = CH_NONE;
    fmt_data_in   = '0;
    fmt_pkt_len   = 2'd0;
    fmt_grant     = 1'b0;
    fmt_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_out_valid", fmt_out_valid, 0);
    check("reset_req", fmt_req, 0);
    check("reset_start_end", {fmt_start, fmt_end}, 0);
    check("reset_data", fmt_data, 0);
    check("reset_chid", fmt_chid, CH_NONE);
    check("reset_arb_valid", fmt_arb_valid, 0);

    // Directed packets with hand-computed parity
    tbl[0] = '{ch: CH1, code: 2'd0, base: 32'h1, mode: 0, sw: 0, gdly: 2,
               exp_par: 32'h4,  exp_beats: 5,  chk_timing: 1'b1};
    tbl[1] = '{ch: CH2, code: 2'd1, base: 32'h3, mode: 1, sw: 0, gdly: 1,
               exp_par: 32'h8,  exp_beats: 9,  chk_timing: 1'b0};
    tbl[2] = '{ch: CH0, code: 2'd0, base: 32'h5, mode: 0, sw: 3, gdly: 0,
               exp_par: 32'hC,  exp_beats: 5,  chk_timing: 1'b0};
    tbl[3] = '{ch: CH1, code: 2'd2, base: 32'h1, mode: 2, sw: 0, gdly: 3,
               exp_par: 32'h10, exp_beats: 17, chk_timing: 1'b0};
    for (int i = 0; i < 4; i++) begin
      run_packet(tbl[i].ch, tbl[i].code, tbl[i].code, tbl[i].mode, tbl[i].gdly,
                 tbl[i].sw, -1, 1'b0, tbl[i].base, 1'b1, tbl[i].exp_par,
                 tbl[i].chk_timing);
      check("table_beats", beats_pkt, tbl[i].exp_beats);
    end

    // Length code changed mid-packet, then a 32-word packet
    run_packet(CH0, 2'd0, 2'd3, 0, 1, 0, -1, 1'b1, '0, 1'b0, '0, 1'b1);
    run_packet(CH1, 2'd3, 2'd0, 0, 1, 0, -1, 1'b1, '0, 1'b0, '0, 1'b1);

    // Reset at payload word 2 of 8, then a clean packet
    run_packet(CH2, 2'd1, 2'd1, 0, 1, 0, 2, 1'b1, '0, 1'b0, '0, 1'b0);
    run_packet(CH2, 2'd0, 2'd0, 0, 1, 0, -1, 1'b1, '0, 1'b0, '0, 1'b1);

    // Grant withheld for 20 cycles
    run_packet(CH1, 2'd0, 2'd2, 0, 20, 0, -1, 1'b1, '0, 1'b0, '0, 1'b1);

    // Random packets
    for (int i = 0; i < 20; i++) begin
      run_packet(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 2),
                 $urandom_range(0, 4), $urandom_range(0, 2), -1, 1'b1,
                 '0, 1'b0, '0, 1'b0);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/formatter.md
Name: formatter

Overview:
- Downlink consumer of the channel arbiter: pulls 32-bit words from whichever channel the arbiter has chosen and packs them into fixed-length packets.
- Packet = N payload words from one channel + one trailing parity word (XOR of the payload).
- Requests the downstream bus before each packet, then streams the packet over a valid/ready output.
- Sits between the arbiter's downlink handshake and the external receiver.

Parameters:
- FIFO_WIDE, 32, data word width (matches arbiter data width)
- CH_NONE, 2'b11, arbiter channel code meaning "no channel chosen"

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fmt_arb_ready  in  1  arbiter has a word available (arbiter's downlink ready)
- fmt_ch_id  in  2  arbiter's chosen channel; CH_NONE = none
- fmt_data_in  in  FIFO_WIDE  arbiter data out
- fmt_arb_valid  out  1  formatter takes the presented word this cycle (drives arbiter's downlink valid)
- fmt_pkt_len  in  2  payload length code: 0=4, 1=8, 2=16, 3=32 words
- fmt_req  out  1  request downstream bus for the next packet
- fmt_grant  in  1  downstream grant; sampled only while fmt_req=1
- fmt_out_valid  out  1  output word valid
- fmt_out_ready  in  1  receiver accepts output word
- fmt_data  out  FIFO_WIDE  output word
- fmt_chid  out  2  channel id of the current packet
- fmt_start  out  1  qualifies the first payload word
- fmt_end  out  1  qualifies the parity word (last word of the packet)

Behaviour:
- States: IDLE, REQ, SEND, PAR, DRAIN.
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; fmt_req, fmt_out_valid, fmt_start and fmt_end = 0; fmt_data=0; fmt_chid=CH_NONE; counter=0; parity=0. Reset mid-packet abandons the packet; no partial tail is emitted.
- IDLE -> REQ when fmt_arb_ready=1 and fmt_ch_id!=CH_NONE.
  - On that edge, latch fmt_ch_id into lock_ch and fmt_pkt_len into len_r.
  - fmt_pkt_len changes at any other time are ignored.
- REQ:
  - fmt_req=1 until fmt_grant=1 is seen.
  - Grant edge: fmt_req drops next cycle; state -> SEND; counter=0; parity=0.
- SEND pull condition (fmt_arb_valid=1): fmt_arb_ready && fmt_ch_id==lock_ch && (!fmt_out_valid || fmt_out_ready). It is purely combinational, with no dependence on fmt_arb_valid.
- Channel switch mid-packet: if the arbiter changes to another channel, do not pull; stall until lock_ch is offered again. A packet never mixes channels.
- On each pull edge:
  - fmt_data <= fmt_data_in; fmt_out_valid <= 1; fmt_chid <= lock_ch.
  - fmt_start <= (counter==0).
  - parity ^= word; counter++.
- Last payload word: when the pulled word is word len-1, state -> PAR.
- PAR: when !fmt_out_valid || fmt_out_ready, load fmt_data=parity, fmt_end=1, fmt_start=0, fmt_out_valid=1; state -> DRAIN.
- DRAIN: on fmt_out_ready with fmt_end=1, fmt_out_valid <= 0, fmt_end <= 0; state -> IDLE.
  - Earliest next packet: fmt_req is reasserted 2 cycles after the parity word is accepted.
- Output hold: fmt_out_valid && !fmt_out_ready holds fmt_data, fmt_chid, fmt_start and fmt_end stable.
- If no new load occurs on an accept edge, fmt_out_valid <= 0.
- Throughput: one word per cycle with fmt_out_ready=1 and the arbiter continuously ready. Packet of N payload words = N+1 output beats, first beat 1 cycle after grant at the earliest.
- fmt_arb_valid = 0 in every state except SEND.
- Counter is 6 bits; len decode 4<<code (max 32).

Decomposition:
- Shared package holds:
  - FIFO_WIDE
  - CH0/CH1/CH2/CH_NONE codes
  - the length-code decode function
  - the state enum
- One natural sub-module, fmt_out_reg: the output holding register with load/accept logic, instantiated once.

Test Plan:
- Single packet: len code 0, CH1 data 0x1..0x4, grant 2 cycles after req, out_ready=1 -> beats 1,2,3,4 then 0x4 (XOR); start on beat1, end on beat5, chid=1, 1 beat/cycle.
- Backpressure: len 8, out_ready toggles 1/0 -> no word lost or duplicated; output held stable while stalled; exactly 8 fmt_arb_valid pulses.
- Channel switch: lock CH0; after 2 words the arbiter offers CH2 for 3 cycles -> fmt_arb_valid=0 for those 3 cycles; resume on CH0; packet contains CH0 data only.
- Length latch: fmt_pkt_len changed 0->3 during SEND -> current packet stays 4 words; next packet is 32 words + parity.
- Reset mid-op: rst=1 for 1 cycle at payload word 2 of 8 -> next cycle out_valid=0, req=0, chid=2'b11; the following packet starts with start=1 and fresh parity.
- No grant: arbiter ready but grant held 0 for 20 cycles -> fmt_req stays 1; fmt_arb_valid=0; no output beats.
